// File: rtl/maxnet_result_collector.sv
// maxnet_result_collector: snapshots MaxNet activations on done rising edge, scans for the winner, presents it via valid/ready.
// Optional sticky overrun output when MAXNET_OVERRUN_FLAG_EN is defined.
module maxnet_result_collector #(
    parameter int N  = 4,
    parameter int W  = 32,
    parameter int IW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           done,
    input  logic [N*W-1:0] act_bus,
    input  logic           res_ready,
    output logic           res_valid,
    output logic [IW-1:0]  res_index,
    output logic [W-1:0]   res_value,
    output logic           res_none,
    output logic           res_multi,
`ifdef MAXNET_OVERRUN_FLAG_EN
    output logic           overrun,
`endif
    output logic           busy
);
    localparam logic [1:0] S_WAIT    = 2'd0;
    localparam logic [1:0] S_SCAN    = 2'd1;
    localparam logic [1:0] S_PRESENT = 2'd2;

    logic [1:0]     state_q, state_d;
    logic           done_prev_q, done_prev_d;
    logic [N*W-1:0] snap_q, snap_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [1:0]     pos_cnt_q, pos_cnt_d;
    logic [IW-1:0]  win_idx_q, win_idx_d;
    logic [W-1:0]   win_val_q, win_val_d;
    logic           res_valid_q, res_valid_d;
    logic [IW-1:0]  res_index_q, res_index_d;
    logic [W-1:0]   res_value_q, res_value_d;
    logic           res_none_q, res_none_d;
    logic           res_multi_q, res_multi_d;
    logic           ev;
    logic [W-1:0]   cur;
    logic           pos;
`ifdef MAXNET_OVERRUN_FLAG_EN
    logic           overrun_q, overrun_d;
`endif

    always_comb begin
        ev          = done && !done_prev_q;
        cur         = snap_q[idx_q*W +: W];
        pos         = !cur[W-1] && (cur != '0);
        done_prev_d = done;
        state_d     = state_q;
        snap_d      = snap_q;
        idx_d       = idx_q;
        pos_cnt_d   = pos_cnt_q;
        win_idx_d   = win_idx_q;
        win_val_d   = win_val_q;
        res_valid_d = res_valid_q;
        res_index_d = res_index_q;
        res_value_d = res_value_q;
        res_none_d  = res_none_q;
        res_multi_d = res_multi_q;
        if (state_q == S_WAIT && ev) begin
            snap_d    = act_bus;
            idx_d     = '0;
            pos_cnt_d = '0;
            win_idx_d = '0;
            win_val_d = '0;
            state_d   = S_SCAN;
        end
        if (state_q == S_SCAN) begin
            // the first positive entry wins; later ones only bump the saturating count
            win_idx_d = (pos && pos_cnt_q == 2'd0) ? idx_q : win_idx_q;
            win_val_d = (pos && pos_cnt_q == 2'd0) ? cur : win_val_q;
            pos_cnt_d = (pos && pos_cnt_q != 2'd2) ? pos_cnt_q + 2'd1 : pos_cnt_q;
            idx_d     = idx_q + IW'(1);
            if (idx_q == IW'(N - 1)) begin
                state_d     = S_PRESENT;
                res_index_d = win_idx_d;
                res_value_d = win_val_d;
                res_none_d  = pos_cnt_d == 2'd0;
                res_multi_d = pos_cnt_d == 2'd2;
            end
        end
        if (state_q == S_PRESENT) begin
            res_valid_d = !(res_valid_q && res_ready);
            state_d     = (res_valid_q && res_ready) ? S_WAIT : S_PRESENT;
        end
`ifdef MAXNET_OVERRUN_FLAG_EN
        overrun_d = ev ? (state_q != S_WAIT) : overrun_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_WAIT;
            done_prev_q <= 1'b1;
            snap_q      <= '0;
            idx_q       <= '0;
            pos_cnt_q   <= '0;
            win_idx_q   <= '0;
            win_val_q   <= '0;
            res_valid_q <= 1'b0;
            res_index_q <= '0;
            res_value_q <= '0;
            res_none_q  <= 1'b0;
            res_multi_q <= 1'b0;
`ifdef MAXNET_OVERRUN_FLAG_EN
            overrun_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            done_prev_q <= done_prev_d;
            snap_q      <= snap_d;
            idx_q       <= idx_d;
            pos_cnt_q   <= pos_cnt_d;
            win_idx_q   <= win_idx_d;
            win_val_q   <= win_val_d;
            res_valid_q <= res_valid_d;
            res_index_q <= res_index_d;
            res_value_q <= res_value_d;
            res_none_q  <= res_none_d;
            res_multi_q <= res_multi_d;
`ifdef MAXNET_OVERRUN_FLAG_EN
            overrun_q   <= overrun_d;
`endif
        end
    end

    assign res_valid = res_valid_q;
    assign res_index = res_index_q;
    assign res_value = res_value_q;
    assign res_none  = res_none_q;
    assign res_multi = res_multi_q;
    assign busy      = state_q != S_WAIT;
`ifdef MAXNET_OVERRUN_FLAG_EN
    assign overrun   = overrun_q;
`endif
endmodule

// File: tb/tb_maxnet_result_collector.sv
// tb_maxnet_result_collector: randomized and directed checks of the result collector against a behavioural winner model.
module tb_maxnet_result_collector;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = $clog2(N);

    logic           clk = 1'b0;
    logic           rst;
    logic           done;
    logic [N*W-1:0] act_bus;
    logic           res_ready;
    logic           res_valid;
    logic [IW-1:0]  res_index;
    logic [W-1:0]   res_value;
    logic           res_none;
    logic           res_multi;
    logic           busy;
`ifdef MAXNET_OVERRUN_FLAG_EN
    logic           overrun;
`endif

    int checks = 0;
    int errors = 0;

    maxnet_result_collector #(.N(N), .W(W), .IW(IW)) dut (
        .clk(clk),
        .rst(rst),
        .done(done),
        .act_bus(act_bus),
        .res_ready(res_ready),
        .res_valid(res_valid),
        .res_index(res_index),
        .res_value(res_value),
        .res_none(res_none),
        .res_multi(res_multi),
`ifdef MAXNET_OVERRUN_FLAG_EN
        .overrun(overrun),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // winner = lowest-numbered strictly positive signed entry
    task automatic model(input logic [N*W-1:0] a, output int ei, output logic [W-1:0] ev,
                         output bit en, output bit em);
        int cnt;
        logic signed [W-1:0] v;
        cnt = 0;
        ei  = 0;
        ev  = '0;
        for (int i = 0; i < N; i++) begin
            v = a[i*W +: W];
            if (v > 0) begin
                if (cnt == 0) begin
                    ei = i;
                    ev = v;
                end
                cnt++;
            end
        end
        en = (cnt == 0);
        em = (cnt > 1);
    endtask

    task automatic fire(input logic [N*W-1:0] a);
        done    = 1'b0;
        act_bus = a;
        @(posedge clk);
        #1 done = 1'b1;
        @(posedge clk);
        #1 act_bus = ~a;
    endtask

    task automatic wait_valid(input string tag);
        int k;
        for (k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (res_valid) break;
        end
        chk(tag, k, N + 1);
    endtask

    task automatic check_fields(input logic [N*W-1:0] a);
        int ei;
        logic [W-1:0] ev;
        bit en, em;
        model(a, ei, ev, en, em);
        chk("res_index", res_index, ei);
        chk("res_value", res_value, ev);
        chk("res_none", res_none, en);
        chk("res_multi", res_multi, em);
    endtask

    task automatic run_one(input logic [N*W-1:0] a);
        res_ready = 1'b1;
        fire(a);
        wait_valid("latency");
        check_fields(a);
        chk("busy_present", busy, 1);
        @(posedge clk);
        #1;
        chk("valid_fall", res_valid, 0);
        chk("busy_wait", busy, 0);
        check_fields(a);
    endtask

    function automatic logic [W-1:0] rand_entry();
        int sel;
        sel = $urandom_range(0, 3);
        return (sel == 0) ? '0 :
               (sel == 1) ? W'($urandom_range(1, 1000)) :
               (sel == 2) ? -W'($urandom_range(1, 1000)) : W'($urandom);
    endfunction

    initial begin
        logic [N*W-1:0] a;
        rst       = 1'b1;
        done      = 1'b1;
        act_bus   = '0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_index", res_index, 0);
        rst     = 1'b0;
        act_bus = {32'd1, 32'd2, 32'd3, 32'd4};
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1 chk("idle_valid", res_valid, 0);
        end
        chk("idle_busy", busy, 0);

        run_one({32'd0, 32'd7, 32'd0, 32'd0});
        run_one({32'hFFFF_FFFE, 32'd9, 32'd0, 32'd5});
        run_one({32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd0});
        run_one({32'd0, 32'd0, 32'd0, 32'd0});
        run_one({32'd11, 32'd0, 32'h8000_0000, 32'd0});

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < N; i++) a[i*W +: W] = rand_entry();
            run_one(a);
        end

        // consumer stall with an overrun event during PRESENT
        a         = {32'd0, 32'd0, 32'd12, 32'hFFFF_FF00};
        res_ready = 1'b0;
        fire(a);
        wait_valid("hold_latency");
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            act_bus = {$urandom, $urandom, $urandom, $urandom};
            done    = (c == 2 || c == 3) ? 1'b0 : 1'b1;
            chk("hold_valid", res_valid, 1);
            chk("hold_index", res_index, 1);
            chk("hold_value", res_value, 12);
            chk("hold_none", res_none, 0);
            chk("hold_multi", res_multi, 0);
        end
`ifdef MAXNET_OVERRUN_FLAG_EN
        chk("overrun_set", overrun, 1);
`endif
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_release", res_valid, 0);
        chk("hold_busy", busy, 0);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1 chk("no_recapture", busy, 0);
        end
        chk("kept_index", res_index, 1);
        chk("kept_value", res_value, 12);

        a = {32'd3, 32'd0, 32'd0, 32'd0};
        run_one(a);
`ifdef MAXNET_OVERRUN_FLAG_EN
        chk("overrun_clr", overrun, 0);
`endif

        // reset in the middle of a scan
        res_ready = 1'b0;
        fire({32'd0, 32'd4, 32'd6, 32'd8});
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_index", res_index, 0);
        chk("mid_rst_value", res_value, 0);
        chk("mid_rst_none", res_none, 0);
        chk("mid_rst_multi", res_multi, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            chk("post_rst_valid", res_valid, 0);
            chk("post_rst_busy", busy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
